// File: rtl/rw_manager_pkg.sv
// Shared constants and state encoding for the rw_manager instruction fetch path.
package rw_manager_pkg;

   localparam int unsigned INST_ADDR_W  = 7;
   localparam int unsigned INST_DATA_W  = 20;
   localparam int unsigned INST_END_BIT = 19;

   // A sequence is cut off after this many delivered words.
   localparam int unsigned RUN_LIMIT    = 128;
   localparam int unsigned RUN_CNT_W    = 8;

   localparam int unsigned FIFO_DEPTH   = 4;
   localparam int unsigned FIFO_CNT_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/rw_manager_inst_fifo.sv
// Four-entry instruction FIFO with a registered head word and synchronous flush.
module rw_manager_inst_fifo
   import rw_manager_pkg::*;
#(
   parameter int unsigned DATA_W = INST_DATA_W
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  pop,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     out_data,
   output logic [FIFO_CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      rd_ptr_nxt;
   logic [FIFO_CNT_W-1:0] count_after_pop;
   logic [FIFO_CNT_W-1:0] count_nxt;
   logic                  do_pop;

   always_comb begin
      do_pop          = pop & out_valid;
      rd_ptr_nxt      = rd_ptr + PTR_W'(do_pop);
      count_after_pop = count - FIFO_CNT_W'(do_pop);
      count_nxt       = count_after_pop + FIFO_CNT_W'(push);
   end

   // Head register: bypass the incoming word when the FIFO would otherwise be empty.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr + PTR_W'(push);
         rd_ptr    <= rd_ptr_nxt;
         count     <= count_nxt;
         out_valid <= (count_nxt != '0);
         if (count_after_pop != '0) begin
            out_data <= mem[rd_ptr_nxt];
         end else if (push) begin
            out_data <= wdata;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/rw_manager_inst_fetch.sv
// Instruction fetch unit: walks the instruction ROM from start_addr and streams words until END.
// Define RW_MGR_INST_PREFETCH_EN for the 4-deep prefetch FIFO (one word per cycle).
module rw_manager_inst_fetch
   import rw_manager_pkg::*;
#(
   parameter int unsigned ADDR_W  = INST_ADDR_W,
   parameter int unsigned DATA_W  = INST_DATA_W,
   parameter int unsigned END_BIT = INST_END_BIT
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              abort,
   output logic [ADDR_W-1:0] rom_rdaddress,
   input  logic [DATA_W-1:0] rom_q,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   fetch_state_e         state;
   fetch_state_e         state_nxt;
   logic [RUN_CNT_W-1:0] run_cnt;
   logic [RUN_CNT_W-1:0] run_cnt_nxt;
   logic [ADDR_W-1:0]    addr_nxt;
   logic                 busy_nxt;
   logic                 done_nxt;
   logic                 err_nxt;
   logic                 hs;
   logic                 head_end;
   logic                 run_last;
   logic                 finish;

   // A handshake ends the run on an END word or on the last word the run limit allows.
   always_comb begin
      hs       = inst_valid & inst_ready;
      head_end = inst_data[END_BIT];
      run_last = (run_cnt == RUN_CNT_W'(RUN_LIMIT - 1));
      finish   = hs & (head_end | run_last);
   end

`ifdef RW_MGR_INST_PREFETCH_EN

   logic                  addr_valid;
   logic                  addr_valid_nxt;
   logic                  q_valid;
   logic                  q_valid_nxt;
   logic                  end_seen;
   logic                  end_seen_nxt;
   logic [RUN_CNT_W-1:0]  fetch_cnt;
   logic [RUN_CNT_W-1:0]  fetch_cnt_nxt;
   logic                  fifo_push;
   logic                  fifo_flush;
   logic [FIFO_CNT_W-1:0] fifo_count;
   logic                  q_end;
   logic                  credit_ok;
   logic                  fetch_req;
   logic                  fetch_last;

   rw_manager_inst_fifo #(.DATA_W(DATA_W)) u_inst_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .wdata     (rom_q),
      .pop       (hs),
      .out_valid (inst_valid),
      .out_data  (inst_data),
      .count     (fifo_count)
   );

   // Words returning after END are dropped; credits count buffered plus in-flight words.
   always_comb begin
      q_end      = rom_q[END_BIT];
      fifo_push  = q_valid & ~end_seen & (state != ST_IDLE);
      credit_ok  = (fifo_count + FIFO_CNT_W'(addr_valid) + FIFO_CNT_W'(q_valid))
                   < FIFO_CNT_W'(FIFO_DEPTH);
      fetch_req  = (state == ST_FETCH) & credit_ok & ~(fifo_push & q_end);
      fetch_last = fetch_req & (fetch_cnt == RUN_CNT_W'(RUN_LIMIT - 1));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         rom_rdaddress <= '0;
         addr_valid    <= 1'b0;
         q_valid       <= 1'b0;
         end_seen      <= 1'b0;
         fetch_cnt     <= '0;
         run_cnt       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         state         <= state_nxt;
         rom_rdaddress <= addr_nxt;
         addr_valid    <= addr_valid_nxt;
         q_valid       <= q_valid_nxt;
         end_seen      <= end_seen_nxt;
         fetch_cnt     <= fetch_cnt_nxt;
         run_cnt       <= run_cnt_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         err           <= err_nxt;
      end
   end

   // FETCH issues reads; ISSUE only drains once fetching has stopped.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start && !abort) state_nxt = ST_FETCH;
         ST_FETCH: begin
            if (abort || finish) begin
               state_nxt = ST_IDLE;
            end else if ((fifo_push && q_end) || fetch_last) begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: if (abort || finish) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      addr_nxt       = rom_rdaddress;
      addr_valid_nxt = 1'b0;
      q_valid_nxt    = addr_valid;
      end_seen_nxt   = end_seen;
      fetch_cnt_nxt  = fetch_cnt;
      run_cnt_nxt    = run_cnt;
      busy_nxt       = busy;
      done_nxt       = 1'b0;
      err_nxt        = 1'b0;
      fifo_flush     = 1'b0;
      case (state)
         ST_IDLE: begin
            q_valid_nxt = 1'b0;
            if (start && !abort) begin
               addr_nxt       = start_addr;
               addr_valid_nxt = 1'b1;
               fetch_cnt_nxt  = RUN_CNT_W'(1);
               run_cnt_nxt    = '0;
               end_seen_nxt   = 1'b0;
               busy_nxt       = 1'b1;
            end
         end
         default: begin
            if (abort || finish) begin
               fifo_flush  = 1'b1;
               q_valid_nxt = 1'b0;
               busy_nxt    = 1'b0;
               if (!abort) begin
                  done_nxt = 1'b1;
                  err_nxt  = run_last & ~head_end;
               end
            end else begin
               if (hs) run_cnt_nxt = run_cnt + RUN_CNT_W'(1);
               if (fetch_req) begin
                  addr_nxt       = rom_rdaddress + ADDR_W'(1);
                  addr_valid_nxt = 1'b1;
                  fetch_cnt_nxt  = fetch_cnt + RUN_CNT_W'(1);
               end
               if (fifo_push && q_end) end_seen_nxt = 1'b1;
            end
         end
      endcase
   end

`else

   logic              valid_nxt;
   logic [DATA_W-1:0] data_nxt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         rom_rdaddress <= '0;
         inst_valid    <= 1'b0;
         inst_data     <= '0;
         run_cnt       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         state         <= state_nxt;
         rom_rdaddress <= addr_nxt;
         inst_valid    <= valid_nxt;
         inst_data     <= data_nxt;
         run_cnt       <= run_cnt_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         err           <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start && !abort) state_nxt = ST_FETCH;
         ST_FETCH: state_nxt = abort ? ST_IDLE : ST_ISSUE;
         ST_ISSUE: begin
            if (abort || finish) begin
               state_nxt = ST_IDLE;
            end else if (hs) begin
               state_nxt = ST_FETCH;
            end
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ISSUE's first cycle captures the ROM word; inst_valid rises the cycle after.
   always_comb begin
      addr_nxt    = rom_rdaddress;
      valid_nxt   = inst_valid;
      data_nxt    = inst_data;
      run_cnt_nxt = run_cnt;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               addr_nxt    = start_addr;
               run_cnt_nxt = '0;
               busy_nxt    = 1'b1;
            end
         end
         ST_FETCH: begin
            if (abort) busy_nxt = 1'b0;
         end
         ST_ISSUE: begin
            if (abort) begin
               valid_nxt = 1'b0;
               busy_nxt  = 1'b0;
            end else if (!inst_valid) begin
               valid_nxt = 1'b1;
               data_nxt  = rom_q;
            end else if (hs) begin
               valid_nxt   = 1'b0;
               run_cnt_nxt = run_cnt + RUN_CNT_W'(1);
               if (finish) begin
                  done_nxt = 1'b1;
                  err_nxt  = run_last & ~head_end;
                  busy_nxt = 1'b0;
               end else begin
                  addr_nxt = rom_rdaddress + ADDR_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

`endif

endmodule
